alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
//
// PURPOSE
//   Multi-cycle sequencer that drives the 8x16 register file (reg_file) and
//   the 16-bit ALU (alu) as a simple register-register machine. Accepts one
//   instruction at a time over a valid/ready handshake and produces the
//   register-file read addresses, the ALU op, and the write-back strobe, address
//   and data. Also keeps a sticky carry flag and a retired-instruction counter.
//
// PARAMETERS
//   DW  16  datapath width (register and ALU width)
//   AW  3   register address width (2**AW registers)
//   CW  8   width of retired-instruction counter
//
// PORTS
//   clk        in   1   clock
//   reset      in   1   one clock; reset is synchronous and active-low
//   ins_valid  in   1   instruction present
//   ins_ready  out  1   controller can accept an instruction
//   ins_op     in   3   000 ADD, 001 SUB, 010 AND, 011 OR, 100 LDI, others NOP
//   ins_rd     in   AW  destination register
//   ins_rs1    in   AW  source A (ALU i0)
//   ins_rs2    in   AW  source B (ALU i1)
//   ins_imm    in   DW  immediate for LDI
//   rd_addr_a  out  AW  to reg_file read port A
//   rd_addr_b  out  AW  to reg_file read port B
//   alu_op     out  2   to ALU: 00 add, 01 sub, 10 and, 11 or
//   alu_o      in   DW  ALU result
//   alu_cout   in   1   ALU carry out
//   wr         out  1   reg_file write enable
//   wr_addr    out  AW  reg_file write address
//   d_in       out  DW  reg_file write data
//   done       out  1   one-cycle pulse: instruction retired
//   carry      out  1   sticky carry flag
//   busy       out  1   state != IDLE
//   ins_count  out  CW  retired instructions, wraps modulo 2**CW
//
// BEHAVIOUR
//   - States: IDLE, READ, EXEC, WB. ins_ready = (state==IDLE); busy = !ins_ready.
//   - Accept on rising clk with ins_valid & ins_ready: latch op/rd/rs1/rs2/imm.
//     ALU ops -> READ; LDI -> WB (result reg <= ins_imm); NOP -> WB.
//   - READ: rd_addr_a=rs1, rd_addr_b=rs2, alu_op=op[1:0] (driven from latched
//     fields, held stable through EXEC). Reg-file read is combinational.
//   - EXEC: at end of cycle, result <= alu_o; ADD/SUB: carry <= alu_cout;
//     AND/OR leave carry unchanged. Next state WB.
//   - WB: wr=1 (0 for NOP), wr_addr=rd, d_in=result; done=1. Next state IDLE.
//     ins_count increments at end of WB (NOP included). LDI leaves carry as is.
//   - Latency: ALU op accept edge -> write edge = 3 cycles after accept
//     (READ, EXEC, WB); LDI/NOP = 1 cycle (WB). Next accept no earlier than
//     the IDLE cycle after WB: no read-after-write hazard, no forwarding.
//   - SUB carry follows ALU convention: carry=1 means no borrow.
//   - ins_valid while busy is ignored; requester must hold fields until accepted.
//   - wr, done are decoded from state and gated with reset: never 1 while
//     reset=0. Outputs only change on clk; no combinational path ins_* -> outputs.
//   - Reset (reset=0 sampled at edge), any state incl. mid-instruction:
//     state=IDLE, in-flight instruction dropped (no write), carry=0,
//     ins_count=0, result=0, latched rd/rs1/rs2/op=0 -> rd_addr_a=rd_addr_b=0,
//     alu_op=00, wr_addr=0, d_in=0, wr=0, done=0, busy=0, ins_ready=1.
//
// TESTING (bench instantiates alu_seq_ctrl + reg_file + alu)
//   1 LDI r1=0x0005, LDI r2=0x0003, ADD r3=r1+r2 -> WB wr=1 wr_addr=3
//     d_in=0x0008, carry=0, ins_count=3, done pulse each, one cycle wide.
//   2 SUB r4=r1-r2 -> d_in=0x0002 carry=1; SUB r5=r2-r1 -> d_in=0xFFFE
//     carry=0; then AND r6=r1&r2 -> 0x0001, carry stays 0; OR r7 -> 0x0007.
//   3 LDI r1=0xFFFF, LDI r2=0x0001, ADD r3 -> d_in=0x0000 carry=1;
//     back-to-back ADD r3=r3+r3 (valid held high) -> reads 0x0000, d_in=0x0000.
//   4 ins_valid held high for 10 cycles with one ADD -> accepted exactly once,
//     ins_ready low for 3 cycles after accept, single wr pulse, ins_count +1.
//   5 reset=0 during EXEC of ADD r3 -> next edge IDLE, wr never 1, carry=0,
//     ins_count=0, ins_ready=1; following LDI executes normally.
//   6 ins_op=111 (NOP) -> done pulses, wr stays 0, ins_count +1; ins_count
//     wraps 0xFF -> 0x00 after 256 retirements.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer for an 8x16 register file and a 16-bit ALU.
// Accepts one instruction at a time over valid/ready, walks it through
// READ -> EXEC -> WB (or straight to WB for LDI/NOP), and keeps a sticky
// carry flag plus a retired-instruction counter.
module alu_seq_ctrl #(
    parameter int DW = 16,
    parameter int AW = 3,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ins_valid,
    output logic          ins_ready,
    input  logic [2:0]    ins_op,
    input  logic [AW-1:0] ins_rd,
    input  logic [AW-1:0] ins_rs1,
    input  logic [AW-1:0] ins_rs2,
    input  logic [DW-1:0] ins_imm,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic [1:0]    alu_op,
    input  logic [DW-1:0] alu_o,
    input  logic          alu_cout,
    output logic          wr,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] d_in,
    output logic          done,
    output logic          carry,
    output logic          busy,
    output logic [CW-1:0] ins_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [2:0] OP_LDI = 3'b100;

    state_t        state;
    state_t        state_nxt;
    logic          accept;

    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rs1_q;
    logic [AW-1:0] rs2_q;
    logic [DW-1:0] result_q;
    logic          carry_q;
    logic [CW-1:0] count_q;

    // Ops 000..011 go through the ALU, 100 is LDI, everything above is NOP.
    logic          op_is_alu;
    logic          op_writes;

    assign op_is_alu = ~op_q[2];
    assign op_writes = op_is_alu | (op_q == OP_LDI);

    // State register; reset drops any in-flight instruction.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived control outputs.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ins_ready = 1'b0;
        done      = 1'b0;
        wr        = 1'b0;
        case (state)
            IDLE: begin
                ins_ready = 1'b1;
                if (ins_valid) begin
                    accept    = 1'b1;
                    state_nxt = ins_op[2] ? WB : READ;
                end
            end
            READ: state_nxt = EXEC;
            EXEC: state_nxt = WB;
            WB: begin
                // Gated with reset so a write is never issued while reset is low.
                done      = reset;
                wr        = reset & op_writes;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy = ~ins_ready;
    end

    // Instruction latch, result register, sticky carry and retire counter.
    // NOTE: all of these are plain flops, so each one gets an explicit reset
    // value; there is no storage array here that would be left unreset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                op_q  <= ins_op;
                rd_q  <= ins_rd;
                rs1_q <= ins_rs1;
                rs2_q <= ins_rs2;
                if (ins_op == OP_LDI) begin
                    result_q <= ins_imm;
                end
            end
            if (state == EXEC) begin
                result_q <= alu_o;
                // Only ADD/SUB (op[1]=0) update carry; AND/OR keep it.
                if (!op_q[1]) begin
                    carry_q <= alu_cout;
                end
            end
            if (state == WB) begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    // Register-file and ALU controls come straight from the latched fields,
    // so they hold steady from READ through EXEC and never see ins_* directly.
    assign rd_addr_a = rs1_q;
    assign rd_addr_b = rs2_q;
    assign alu_op    = op_q[1:0];
    assign wr_addr   = rd_q;
    assign d_in      = result_q;
    assign carry     = carry_q;
    assign ins_count = count_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural register file and ALU around the DUT,
// directed scenarios plus random instructions scored against a reference model.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ins_valid;
    logic        ins_ready;
    logic [2:0]  ins_op;
    logic [2:0]  ins_rd;
    logic [2:0]  ins_rs1;
    logic [2:0]  ins_rs2;
    logic [15:0] ins_imm;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_o;
    logic        alu_cout;
    logic        wr;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;
    logic        done;
    logic        carry;
    logic        busy;
    logic [7:0]  ins_count;

    int errors = 0;
    int checks = 0;
    int wr_pulses = 0;

    // Environment register file (storage the DUT drives) and the reference
    // model's own view of the architectural state.
    logic [15:0] env_rf [8];
    logic [15:0] ref_rf [8];
    logic        ref_carry;
    logic [7:0]  ref_count;
    logic [15:0] last_d;

    alu_seq_ctrl #(.DW(16), .AW(3), .CW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_op    (ins_op),
        .ins_rd    (ins_rd),
        .ins_rs1   (ins_rs1),
        .ins_rs2   (ins_rs2),
        .ins_imm   (ins_imm),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .alu_op    (alu_op),
        .alu_o     (alu_o),
        .alu_cout  (alu_cout),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .done      (done),
        .carry     (carry),
        .busy      (busy),
        .ins_count (ins_count)
    );

    always #5 clk = ~clk;

    // Register file: synchronous write, combinational read.
    always @(posedge clk) begin
        if (wr) env_rf[wr_addr] <= d_in;
    end

    // ALU: carry out of a 17-bit sum; SUB is a + ~b + 1 (carry = no borrow).
    always_comb begin
        alu_o    = '0;
        alu_cout = 1'b0;
        case (alu_op)
            2'b00: {alu_cout, alu_o} = {1'b0, env_rf[rd_addr_a]} + {1'b0, env_rf[rd_addr_b]};
            2'b01: {alu_cout, alu_o} = {1'b0, env_rf[rd_addr_a]} + {1'b0, ~env_rf[rd_addr_b]} + 17'd1;
            2'b10: alu_o = env_rf[rd_addr_a] & env_rf[rd_addr_b];
            default: alu_o = env_rf[rd_addr_a] | env_rf[rd_addr_b];
        endcase
    end

    always @(negedge clk) begin
        if (wr) wr_pulses <= wr_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one instruction, wait for it to retire, and score it.
    // With hold=1, ins_valid stays high after acceptance.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] imm, input bit hold);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_d;
        logic        exp_c;
        bit          exp_wr;
        int          exp_lat;
        int          lat;
        bit          seen;
        int          wr_before;

        a       = ref_rf[rs1];
        b       = ref_rf[rs2];
        exp_c   = ref_carry;
        exp_d   = '0;
        exp_wr  = (op <= 3'd4);
        exp_lat = (op < 3'd4) ? 3 : 1;
        case (op)
            3'd0: begin exp_d = a + b; exp_c = (int'(a) + int'(b)) > 65535; end
            3'd1: begin exp_d = a - b; exp_c = (a >= b); end
            3'd2: exp_d = a & b;
            3'd3: exp_d = a | b;
            3'd4: exp_d = imm;
            default: exp_d = '0;
        endcase

        ins_op    = op;
        ins_rd    = rd;
        ins_rs1   = rs1;
        ins_rs2   = rs2;
        ins_imm   = imm;
        ins_valid = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ins_ready) seen = 1'b1;
        end
        check("accept_ready", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) ins_valid = 1'b0;
        wr_before = wr_pulses;

        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            check("busy_ready", 32'(ins_ready), 32'd0);
            check("busy", 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", lat, exp_lat);
        check("wr", 32'(wr), 32'(exp_wr));
        if (exp_wr) begin
            check("wr_addr", 32'(wr_addr), 32'(rd));
            check("d_in", 32'(d_in), 32'(exp_d));
        end
        last_d = d_in;
        @(posedge clk);
        #1;

        if (exp_wr) ref_rf[rd] = exp_d;
        ref_carry = exp_c;
        ref_count = ref_count + 8'd1;

        check("done_width", 32'(done), 32'd0);
        check("ready_after", 32'(ins_ready), 32'd1);
        check("carry", 32'(carry), 32'(ref_carry));
        check("ins_count", 32'(ins_count), 32'(ref_count));
        check("wr_pulses", wr_pulses - wr_before, 32'(exp_wr));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 32'(ins_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_wr"}, 32'(wr), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_carry"}, 32'(carry), 32'd0);
        check({tag, "_count"}, 32'(ins_count), 32'd0);
        check({tag, "_addr_a"}, 32'(rd_addr_a), 32'd0);
        check({tag, "_addr_b"}, 32'(rd_addr_b), 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_d_in"}, 32'(d_in), 32'd0);
    endtask

    initial begin
        int wr_before;
        for (int i = 0; i < 8; i++) begin
            env_rf[i] = '0;
            ref_rf[i] = '0;
        end
        ref_carry = 1'b0;
        ref_count = '0;
        last_d    = '0;
        reset     = 1'b0;
        ins_valid = 1'b1;
        ins_op    = 3'd4;
        ins_rd    = 3'd7;
        ins_rs1   = 3'd5;
        ins_rs2   = 3'd6;
        ins_imm   = 16'hBEEF;

        // Power-on reset, with a valid instruction offered that must be ignored.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");
        ins_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: LDI, LDI, ADD.
        issue(3'd4, 3'd1, 3'd0, 3'd0, 16'h0005, 1'b0);
        issue(3'd4, 3'd2, 3'd0, 3'd0, 16'h0003, 1'b0);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0);
        check("s1_sum", 32'(last_d), 32'h0008);
        check("s1_carry", 32'(carry), 32'd0);
        check("s1_count", 32'(ins_count), 32'd3);

        // 2: SUB both ways, AND, OR.
        issue(3'd1, 3'd4, 3'd1, 3'd2, 16'h0000, 1'b0);
        check("s2_sub", 32'(last_d), 32'h0002);
        check("s2_sub_carry", 32'(carry), 32'd1);
        issue(3'd1, 3'd5, 3'd2, 3'd1, 16'h0000, 1'b0);
        check("s2_subn", 32'(last_d), 32'hFFFE);
        check("s2_subn_carry", 32'(carry), 32'd0);
        issue(3'd2, 3'd6, 3'd1, 3'd2, 16'h0000, 1'b0);
        check("s2_and", 32'(last_d), 32'h0001);
        check("s2_and_carry", 32'(carry), 32'd0);
        issue(3'd3, 3'd7, 3'd1, 3'd2, 16'h0000, 1'b0);
        check("s2_or", 32'(last_d), 32'h0007);

        // 3: overflow ADD, then back-to-back dependent ADD with valid held high.
        issue(3'd4, 3'd1, 3'd0, 3'd0, 16'hFFFF, 1'b0);
        issue(3'd4, 3'd2, 3'd0, 3'd0, 16'h0001, 1'b0);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b1);
        check("s3_ovf_sum", 32'(last_d), 32'h0000);
        check("s3_ovf_carry", 32'(carry), 32'd1);
        issue(3'd0, 3'd3, 3'd3, 3'd3, 16'h0000, 1'b0);
        check("s3_b2b_sum", 32'(last_d), 32'h0000);

        // 4: valid held through the whole busy window, single acceptance.
        wr_before = wr_pulses;
        issue(3'd0, 3'd4, 3'd4, 3'd5, 16'h0000, 1'b1);
        ins_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("s4_single_wr", wr_pulses - wr_before, 32'd1);
        check("s4_count", 32'(ins_count), 32'(ref_count));

        // 5a: reset during EXEC of ADD r3.
        wr_before = wr_pulses;
        ins_op = 3'd0; ins_rd = 3'd3; ins_rs1 = 3'd1; ins_rs2 = 3'd2; ins_imm = '0;
        ins_valid = 1'b1;
        @(negedge clk);
        check("s5_ready", 32'(ins_ready), 32'd1);
        @(posedge clk);
        #1;
        ins_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("s5_exec_wr", 32'(wr), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        ref_carry = 1'b0;
        ref_count = '0;
        check_reset_state("s5_exec");
        repeat (4) @(posedge clk);
        #1;
        check("s5_no_wr", wr_pulses - wr_before, 32'd0);

        // 5b: reset landing in WB of an LDI: write and done must be suppressed.
        ins_op = 3'd4; ins_rd = 3'd5; ins_imm = 16'h1234;
        ins_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        ins_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("s5_wb_wr", 32'(wr), 32'd0);
        check("s5_wb_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_reset_state("s5_wb");
        check("s5_wb_no_wr", wr_pulses - wr_before, 32'd0);

        // Normal execution resumes after reset.
        issue(3'd4, 3'd6, 3'd0, 3'd0, 16'hA5A5, 1'b0);
        check("s5_ldi_after", 32'(last_d), 32'hA5A5);

        // 6: NOP retires without writing.
        issue(3'd7, 3'd1, 3'd2, 3'd3, 16'h0000, 1'b0);
        check("s6_nop_count", 32'(ins_count), 32'd2);

        // Random instructions; 254 more brings the post-reset total to 256.
        for (int n = 0; n < 254; n++) begin
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 16'($urandom), 1'b0);
        end
        check("s6_wrap", 32'(ins_count), 32'd0);

        // A few more random instructions with valid held back-to-back.
        for (int n = 0; n < 40; n++) begin
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 16'($urandom), n != 39);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
